// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes the raw pins and deframes 11-bit frames.
// It tracks make/break codes and keeps a BCD count of new key presses.
module ps2_key_rx #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_down,
    output logic [7:0] press_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fe;
    logic          sd;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmr;
    logic          timeout;
    logic          break_pending;
    logic [7:0]    cnt_next;

    assign fe      = clk_sync[2] & ~clk_sync[1];
    assign sd      = dat_sync[1];
    assign timeout = (bit_idx != 4'd0) && (tmr == T_LAST);

    // Synchronizers preset to the idle-bus level so reset creates no edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_idx   <= 4'd0;
            shreg     <= 8'h00;
            par       <= 1'b0;
            tmr       <= '0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            // An edge coinciding with expiry is discarded with the frame.
            if (timeout) begin
                bit_idx   <= 4'd0;
                tmr       <= '0;
                frame_err <= 1'b1;
            end else begin
                if (fe) begin
                    tmr <= '0;
                end else if (bit_idx != 4'd0) begin
                    tmr <= tmr + 1'b1;
                end
                if (fe) begin
                    if (bit_idx == 4'd0) begin
                        if (!sd) begin
                            bit_idx <= 4'd1;
                        end
                    end else if (bit_idx <= 4'd8) begin
                        shreg   <= {sd, shreg[7:1]};
                        bit_idx <= bit_idx + 4'd1;
                    end else if (bit_idx == 4'd9) begin
                        par     <= sd;
                        bit_idx <= 4'd10;
                    end else begin
                        bit_idx <= 4'd0;
                        if ((^shreg ^ par) && sd) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_next = press_cnt;
        if (press_cnt[3:0] == 4'd9) begin
            cnt_next[3:0] = 4'd0;
            if (press_cnt[7:4] == 4'd9) begin
                cnt_next[7:4] = 4'd0;
            end else begin
                cnt_next[7:4] = press_cnt[7:4] + 4'd1;
            end
        end else begin
            cnt_next[3:0] = press_cnt[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_code      <= 8'h00;
            key_down      <= 1'b0;
            press_cnt     <= 8'h00;
            break_pending <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
                break_pending <= break_pending;
            end else if (rx_byte == 8'hF0) begin
                break_pending <= 1'b1;
            end else if (break_pending) begin
                break_pending <= 1'b0;
                if (rx_byte == key_code) begin
                    key_down <= 1'b0;
                end
            end else if (!(key_down && rx_byte == key_code)) begin
                key_code  <= rx_byte;
                key_down  <= 1'b1;
                press_cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus queues expected events,
// a negedge monitor pops and compares on every rx_valid/frame_err.
module tb_ps2_key_rx;

    localparam int TO = 64;
    localparam int H  = 4;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_down;
    logic [7:0] press_cnt;

    ps2_key_rx #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .key_code  (key_code),
        .key_down  (key_down),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] b;
        logic [7:0] k;
        bit         d;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] m_key;
    bit         m_down;
    bit         m_brk;
    int         m_cnt;

    bit         trk_pend = 1'b0;
    exp_t       cur;
    logic [7:0] prev_cnt = 8'h00;
    bit         seen_09_10 = 1'b0;
    bit         seen_99_00 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_key  = 8'h00;
        m_down = 1'b0;
        m_brk  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic push(input bit err, input logic [7:0] b);
        exp_t e;
        if (!err) begin
            if (b == 8'hE0) begin
                m_brk = m_brk;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (m_brk) begin
                m_brk = 1'b0;
                if (b == m_key) m_down = 1'b0;
            end else if (!(m_down && b == m_key)) begin
                m_key  = b;
                m_down = 1'b1;
                m_cnt  = (m_cnt + 1) % 100;
            end
        end
        e.err = err;
        e.b   = b;
        e.k   = m_key;
        e.d   = m_down;
        e.c   = bcd(m_cnt);
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b,
                                          input bit perr, input bit serr);
        return {~serr, (~^b) ^ perr, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit perr,
                             input bit serr);
        push(perr | serr, b);
        send_bits(frame(b, perr, serr), 11);
        ps2_data = 1'b1;
        tick(2 * H);
    endtask

    always @(negedge clk) begin
        if (trk_pend) begin
            trk_pend = 1'b0;
            chk("key_code", 32'(key_code), 32'(cur.k));
            chk("key_down", 32'(key_down), 32'(cur.d));
            chk("press_cnt", 32'(press_cnt), 32'(cur.c));
            chk("bcd_nibbles",
                32'((press_cnt[7:4] <= 4'd9) && (press_cnt[3:0] <= 4'd9)),
                32'd1);
            if (prev_cnt == 8'h09 && press_cnt == 8'h10) seen_09_10 = 1'b1;
            if (prev_cnt == 8'h99 && press_cnt == 8'h00) seen_99_00 = 1'b1;
            prev_cnt = press_cnt;
        end
        if (rx_valid || frame_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {30'd0, rx_valid, frame_err}, 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("both_pulses", 32'(rx_valid & frame_err), 32'd0);
                chk("frame_err", 32'(frame_err), 32'(cur.err));
                if (!cur.err) chk("rx_byte", 32'(rx_byte), 32'(cur.b));
                trk_pend = 1'b1;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        tick(3);
        chk("rst_rx_byte", 32'(rx_byte), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_press_cnt", 32'(press_cnt), 32'd0);
        clrn = 1'b1;
        tick(5);

        send_byte(8'h1C, 1'b0, 1'b0);
        chk("t1_key", 32'(key_code), 32'h1C);
        chk("t1_down", 32'(key_down), 32'd1);
        chk("t1_cnt", 32'(press_cnt), 32'h01);

        for (int i = 0; i < 3; i++) send_byte(8'h1C, 1'b0, 1'b0);
        chk("typ_cnt", 32'(press_cnt), 32'h01);
        send_byte(8'hF0, 1'b0, 1'b0);
        chk("typ_down_held", 32'(key_down), 32'd1);
        send_byte(8'h1C, 1'b0, 1'b0);
        chk("rel_down", 32'(key_down), 32'd0);
        chk("rel_key", 32'(key_code), 32'h1C);

        send_byte(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b1);
        chk("err_cnt", 32'(press_cnt), 32'h01);
        chk("err_down", 32'(key_down), 32'd0);

        push(1'b1, 8'h00);
        send_bits(frame(8'h1C, 1'b0, 1'b0), 5);
        ps2_data = 1'b1;
        tick(TO + 40);
        send_byte(8'h32, 1'b0, 1'b0);
        chk("to_rx_byte", 32'(rx_byte), 32'h32);
        chk("to_key", 32'(key_code), 32'h32);
        chk("to_cnt", 32'(press_cnt), 32'h02);

        for (int i = 0; i < 100; i++) begin
            logic [7:0] k;
            k = (i % 2 == 0) ? 8'h1C : 8'h32;
            send_byte(k, 1'b0, 1'b0);
            send_byte(8'hF0, 1'b0, 1'b0);
            send_byte(k, 1'b0, 1'b0);
        end
        chk("wrap_cnt", 32'(press_cnt), 32'h02);
        chk("seen_09_10", 32'(seen_09_10), 32'd1);
        chk("seen_99_00", 32'(seen_99_00), 32'd1);

        send_bits(frame(8'h1C, 1'b0, 1'b0), 4);
        ps2_data = 1'b1;
        clrn = 1'b0;
        tick(3);
        chk("mid_rx_byte", 32'(rx_byte), 32'd0);
        chk("mid_rx_valid", 32'(rx_valid), 32'd0);
        chk("mid_frame_err", 32'(frame_err), 32'd0);
        chk("mid_key_code", 32'(key_code), 32'd0);
        chk("mid_key_down", 32'(key_down), 32'd0);
        chk("mid_press_cnt", 32'(press_cnt), 32'd0);
        model_reset();
        prev_cnt = 8'h00;
        clrn = 1'b1;
        tick(5);
        send_byte(8'hE0, 1'b0, 1'b0);
        chk("ext_cnt", 32'(press_cnt), 32'h00);
        send_byte(8'h75, 1'b0, 1'b0);
        chk("ext_key", 32'(key_code), 32'h75);
        chk("ext_cnt2", 32'(press_cnt), 32'h01);

        tick(20);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
